// File: rtl/seq_divider_if.sv
// Start/done handshake bundle shared by the sequential divider and its controller.
// The controller owns the request and operands; the divider owns results and status.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned quotient/remainder at one bit per clock,
// using the same start/done handshake as the shift-add multiplier.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DZ   = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] dvd_r;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;
    logic             last_s;

    // One restoring step. The stored partial remainder is always below the divisor,
    // so it fits WIDTH bits; the shifted value and trial difference carry the extra bit.
    always_comb begin
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, dvs_r};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_nx_s = trial_s[WIDTH-1:0];
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx_s = rem_sh_s[WIDTH-1:0];
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        last_s = (count_r == CW'(WIDTH - 1));
    end

    // Control FSM with working registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            count_r         <= {CW{1'b0}};
            rem_r           <= {WIDTH{1'b0}};
            quo_r           <= {WIDTH{1'b0}};
            dvs_r           <= {WIDTH{1'b0}};
            dvd_r           <= {WIDTH{1'b0}};
            bus.quotient    <= {WIDTH{1'b0}};
            bus.remainder   <= {WIDTH{1'b0}};
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        dvd_r           <= bus.dividend;
                        dvs_r           <= bus.divisor;
                        bus.div_by_zero <= 1'b0;
                        bus.busy        <= 1'b1;
                        if (bus.divisor == {WIDTH{1'b0}}) begin
                            state_r <= DZ;
                        end else begin
                            count_r <= {CW{1'b0}};
                            rem_r   <= {WIDTH{1'b0}};
                            quo_r   <= bus.dividend;
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r   <= rem_nx_s;
                    quo_r   <= quo_nx_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        bus.quotient  <= quo_nx_s;
                        bus.remainder <= rem_nx_s;
                        bus.done      <= 1'b1;
                        bus.busy      <= 1'b0;
                        state_r       <= IDLE;
                    end else begin
                        bus.done <= 1'b0;
                        state_r  <= CALC;
                    end
                end
                DZ: begin
                    bus.quotient    <= {WIDTH{1'b1}};
                    bus.remainder   <= dvd_r;
                    bus.div_by_zero <= 1'b1;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state_r         <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: handshake timing, boundary operands, divide-by-zero,
// busy-start rejection, mid-operation reset, level-held start, 4-bit sweep and an 8-bit case.
module tb_seq_divider;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    seq_divider_if #(.WIDTH(4)) bus ();
    seq_divider_if #(.WIDTH(8)) bus8 ();

    seq_divider #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns one ns after the accepting edge E0, with garbage on the operand lines.
    task automatic start4(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
    endtask

    task automatic wait_done4(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic div4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int eq, input int er, input int edz, input int elat);
        int lat;
        start4(a, b);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done4(lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, 32'(bus.quotient), eq);
        chk({tag, "_r"}, 32'(bus.remainder), er);
        chk({tag, "_dz"}, 32'(bus.div_by_zero), edz);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold_q"}, 32'(bus.quotient), eq);
    endtask

    initial begin
        int nd;
        int lat;
        int cyc;
        int n;
        int qv;
        int rv;
        int times [3];
        logic ok;

        bus.start     = 1'b0;
        bus.dividend  = 4'd0;
        bus.divisor   = 4'd0;
        bus8.start    = 1'b0;
        bus8.dividend = 8'd0;
        bus8.divisor  = 8'd0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        div4("d13_3", 4'd13, 4'd3, 4, 1, 0, 4);
        div4("d15_1", 4'd15, 4'd1, 15, 0, 0, 4);
        div4("d5_7", 4'd5, 4'd7, 0, 5, 0, 4);
        div4("d0_9", 4'd0, 4'd9, 0, 0, 0, 4);
        div4("d15_15", 4'd15, 4'd15, 1, 0, 0, 4);
        div4("d9_0", 4'd9, 4'd0, 15, 9, 1, 1);
        div4("d8_2", 4'd8, 4'd2, 4, 0, 0, 4);

        // start pulsed at E0+2 while busy must be ignored
        start4(4'd13, 4'd3);
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd6;
        bus.divisor  = 4'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        nd = 0;
        qv = -1;
        rv = -1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                nd++;
                qv = int'(bus.quotient);
                rv = int'(bus.remainder);
            end
        end
        chk("busy_start_ndone", nd, 1);
        chk("busy_start_q", qv, 4);
        chk("busy_start_r", rv, 1);

        // reset mid-operation
        start4(4'd12, 4'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_q", 32'(bus.quotient), 32'd0);
        chk("arst_r", 32'(bus.remainder), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_dz", 32'(bus.div_by_zero), 32'd0);
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) nd++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) nd++;
        end
        chk("arst_no_done", nd, 0);
        div4("d12_5", 4'd12, 4'd5, 2, 2, 0, 4);

        // level-held start: three back-to-back operations
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd13;
        bus.divisor  = 4'd3;
        cyc = 0;
        n   = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done === 1'b1) begin
                times[n] = cyc;
                n++;
            end
        end
        bus.start = 1'b0;
        chk("held_count", n, 3);
        chk("held_first", times[0], 5);
        chk("held_gap1", times[1] - times[0], 5);
        chk("held_gap2", times[2] - times[1], 5);
        chk("held_q", 32'(bus.quotient), 32'd4);
        chk("held_r", 32'(bus.remainder), 32'd1);
        nd = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) nd++;
        end
        chk("held_stop", nd, 0);
        chk("held_idle_busy", 32'(bus.busy), 32'd0);

        // exhaustive 4-bit sweep against the division invariant
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start4(4'(a), 4'(b));
                wait_done4(lat);
                qv = int'(bus.quotient);
                rv = int'(bus.remainder);
                if (b == 0)
                    ok = (lat == 1) && (qv == 15) && (rv == a) && (bus.div_by_zero === 1'b1);
                else
                    ok = (lat == 4) && (qv * b + rv == a) && (rv < b) && (bus.div_by_zero === 1'b0);
                total++;
                assert (ok === 1'b1) else begin
                    bad++;
                    $error("FAIL sweep %0d/%0d: observed q=%0d r=%0d lat=%0d expected invariant to hold",
                           a, b, qv, rv, lat);
                end
            end
        end

        // 8-bit instance
        @(negedge clk);
        bus8.start    = 1'b1;
        bus8.dividend = 8'd200;
        bus8.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus8.start    = 1'b0;
        bus8.dividend = 8'd3;
        bus8.divisor  = 8'd1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus8.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("w8_lat", lat, 8);
        chk("w8_q", 32'(bus8.quotient), 32'd28);
        chk("w8_r", 32'(bus8.remainder), 32'd4);
        chk("w8_dz", 32'(bus8.div_by_zero), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
